// File: rtl/tidc_pkg.sv
// Shared definitions for the TIDC L2 backing store: command encodings,
// line geometry, FSM state type and the buffered command record.
package tidc_pkg;

    localparam logic [2:0] CMD_READ  = 3'd0;
    localparam logic [2:0] CMD_WRITE = 3'd1;
    localparam logic [2:0] CMD_FLUSH = 3'd2;

    localparam int unsigned LINE_BYTES     = 64;
    localparam int unsigned LINE_SIZE_LOG2 = 6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_RESP
    } state_t;

    typedef struct packed {
        logic [2:0]              ctype;
        logic [63:0]             addr;
        logic [LINE_BYTES*8-1:0] data;
        logic [3:0]              size;
        logic                    dirty;
    } cmd_t;

endpackage

// File: rtl/tidc_cmd_fifo.sv
// In-order command FIFO with wrap-bit pointers; push and pop may occur in the
// same cycle, including while full.
module tidc_cmd_fifo #(
    parameter int unsigned WIDTH = 584,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      r_wr;
    logic [AW:0]      r_rd;
    logic [WIDTH-1:0] r_mem [DEPTH];

    assign o_empty = (r_wr == r_rd);
    assign o_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign o_data  = r_mem[r_rd[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (i_push) r_wr <= r_wr + 1'b1;
            if (i_pop)  r_rd <= r_rd + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/tidc_l2_backing_store.sv
// L2 backing store responder: buffers l2_cmd_* commands, services each after
// LATENCY cycles against a line store. Optional counters: TIDC_BS_STATS_EN.
module tidc_l2_backing_store
    import tidc_pkg::*;
#(
    parameter int unsigned LINES      = 16,
    parameter int unsigned LATENCY    = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         l2_cmd_valid,
    input  logic [2:0]   l2_cmd_type,
    input  logic [63:0]  l2_cmd_addr,
    input  logic [511:0] l2_cmd_data,
    input  logic [3:0]   l2_cmd_size,
    input  logic         l2_cmd_dirty,
    output logic         l2_response_valid,
    output logic [511:0] l2_response_data,
    output logic         l2_response_error,
    output logic         overflow
`ifdef TIDC_BS_STATS_EN
    ,
    output logic [31:0]  stat_reads,
    output logic [31:0]  stat_writes,
    output logic [31:0]  stat_errors
`endif
);

    localparam int unsigned IDXW = $clog2(LINES);

    state_t          r_state;
    logic [7:0]      r_cnt;
    cmd_t            r_cmd;
    logic            r_resp_valid;
    logic            r_resp_error;
    logic [511:0]    r_resp_data;
    logic            r_overflow;
    logic [LINES-1:0] r_vld;
    logic [511:0]    r_mem [LINES];

    cmd_t            w_in;
    cmd_t            w_out;
    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic [IDXW-1:0] w_idx;
    logic            w_in_range;
    logic            w_err;
    logic            w_store;
    logic            w_is_read;
    logic            w_commit;

    assign w_in   = '{ctype: l2_cmd_type, addr: l2_cmd_addr, data: l2_cmd_data,
                      size: l2_cmd_size, dirty: l2_cmd_dirty};
    assign w_pop  = (r_state == ST_IDLE) && !w_empty;
    assign w_push = l2_cmd_valid && (!w_full || w_pop);

    tidc_cmd_fifo #(
        .WIDTH ($bits(cmd_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_in),
        .i_pop   (w_pop),
        .o_data  (w_out),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Decode of the command held in r_cmd; stays valid through RESP.
    assign w_idx      = r_cmd.addr[LINE_SIZE_LOG2 +: IDXW];
    assign w_in_range = (r_cmd.addr[LINE_SIZE_LOG2-1:0] == '0) &&
                        ((r_cmd.addr >> (LINE_SIZE_LOG2 + IDXW)) == '0);
    assign w_err      = (r_cmd.ctype > CMD_FLUSH) ||
                        (r_cmd.size != 4'(LINE_SIZE_LOG2)) || !w_in_range;
    assign w_store    = !w_err && ((r_cmd.ctype == CMD_WRITE) ||
                                   ((r_cmd.ctype == CMD_FLUSH) && r_cmd.dirty));
    assign w_is_read  = !w_err && (r_cmd.ctype == CMD_READ);
    assign w_commit   = (r_state == ST_BUSY) && (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (w_commit && w_store) r_mem[w_idx] <= r_cmd.data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_cmd        <= '0;
            r_resp_valid <= 1'b0;
            r_resp_error <= 1'b0;
            r_resp_data  <= '0;
            r_overflow   <= 1'b0;
            r_vld        <= '0;
        end else begin
            if (l2_cmd_valid && w_full && !w_pop) r_overflow <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        r_cmd   <= w_out;
                        r_cnt   <= 8'(LATENCY - 1);
                        r_state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (r_cnt == '0) begin
                        r_resp_valid <= 1'b1;
                        r_resp_error <= w_err;
                        r_resp_data  <= (w_is_read && r_vld[w_idx]) ? r_mem[w_idx] : '0;
                        if (w_store) r_vld[w_idx] <= 1'b1;
                        r_state <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                ST_RESP: begin
                    r_resp_valid <= 1'b0;
                    r_resp_error <= 1'b0;
                    r_resp_data  <= '0;
                    r_state      <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign l2_response_valid = r_resp_valid;
    assign l2_response_data  = r_resp_data;
    assign l2_response_error = r_resp_error;
    assign overflow          = r_overflow;

`ifdef TIDC_BS_STATS_EN
    logic [31:0] r_stat_reads;
    logic [31:0] r_stat_writes;
    logic [31:0] r_stat_errors;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_reads  <= '0;
            r_stat_writes <= '0;
            r_stat_errors <= '0;
        end else if (r_state == ST_RESP) begin
            if (w_is_read && (r_stat_reads != '1))  r_stat_reads  <= r_stat_reads + 32'd1;
            if (w_store   && (r_stat_writes != '1)) r_stat_writes <= r_stat_writes + 32'd1;
            if (w_err     && (r_stat_errors != '1)) r_stat_errors <= r_stat_errors + 32'd1;
        end
    end

    assign stat_reads  = r_stat_reads;
    assign stat_writes = r_stat_writes;
    assign stat_errors = r_stat_errors;
`endif

endmodule
